axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_slave_pkg.sv | 21 ++
 rtl/axi_sram_slave.sv | 151 +++++++++++++++
 tb/tb_axi_sram_slave.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave: FSM encoding, response codes, field widths.
package axi_slave_pkg;

  localparam int ID_W       = 4;
  localparam int LEN_W      = 4;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int BEAT_BYTES = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD_REQ,
    S_RD_CAP,
    S_RD_DATA
  } state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst slave bridging one outstanding transaction onto a single-port SRAM.
// Latency: write beats zero-wait; read beat valid 3 cycles after AR or previous R handshake.
// Backpressure: wready only in WR; R/B outputs hold stable until rready/bready; no new AW/AR until done.
module axi_sram_slave
  import axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [LEN_W-1:0]      awlen,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [LEN_W-1:0]      arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  sram_en,
  output logic [STRB_W-1:0]     sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] BEAT_INC   = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BEAT_BYTES - 1));

  state_t                state;
  logic [ID_W-1:0]       id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;
  logic                  rd_en_q;
  logic                  wr_fire;

  // Read wins a simultaneous request, so AW is only offered while AR is quiet.
  assign awready    = arready & ~arvalid;
  assign wr_fire    = wready & wvalid;
  assign sram_en    = rd_en_q | wr_fire;
  assign sram_we    = wr_fire ? wstrb : '0;
  assign sram_wdata = wr_fire ? wdata : '0;
  assign sram_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      arready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rd_en_q <= 1'b0;
      bid     <= '0;
      rid     <= '0;
      bresp   <= '0;
      rresp   <= '0;
      rdata   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            id_q    <= arid;
            addr_q  <= araddr & ALIGN_MASK;
            len_q   <= arlen;
            cnt_q   <= '0;
            arready <= 1'b0;
            rd_en_q <= 1'b1;
            state   <= S_RD_REQ;
          end else if (awvalid && awready) begin
            id_q    <= awid;
            addr_q  <= awaddr & ALIGN_MASK;
            len_q   <= awlen;
            cnt_q   <= '0;
            arready <= 1'b0;
            wready  <= 1'b1;
            state   <= S_WR;
          end
        end
        S_WR: begin
          if (wvalid) begin
            addr_q <= addr_q + BEAT_INC;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == len_q) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= RESP_OKAY;
              state  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          rdata  <= sram_rdata;
          rvalid <= 1'b1;
          rid    <= id_q;
          rresp  <= RESP_OKAY;
          rlast  <= (cnt_q == len_q);
          state  <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            addr_q <= addr_q + BEAT_INC;
            cnt_q  <= cnt_q + 1'b1;
            if (rlast) begin
              arready <= 1'b1;
              state   <= S_IDLE;
            end else begin
              rd_en_q <= 1'b1;
              state   <= S_RD_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized AXI bursts against a word-array memory model; SRAM is a 256-word behavioural array.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  awid, arid, awlen, arlen, wstrb;
  logic [31:0] awaddr, araddr, wdata;
  logic        awvalid, arvalid, wvalid, bready, rready;
  logic        awready, arready, wready, bvalid, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  logic        sram_clr;
  logic [31:0] sram_mem [256];
  logic [31:0] ref_mem  [256];
  int          total = 0;
  int          bad   = 0;
  int          aw_wait;

  axi_sram_slave #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int k = 0; k < 256; k++) sram_mem[k] <= 32'h0;
      sram_rdata <= 32'h0;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= sram_mem[sram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rlast"}, rlast, 0);
    chk({tag, "_sram_en"}, sram_en, 0);
    chk({tag, "_sram_we"}, sram_we, 0);
    chk({tag, "_bid"}, bid, 0);
    chk({tag, "_rid"}, rid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
  endtask

  // Called at a falling edge; returns just after a falling edge.
  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input bit rnd, input int abort_at);
    logic [31:0] ea, d;
    logic [3:0]  s;
    int          n;
    ea = a & 32'hFFFF_FFFC;
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len;
    #1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    chk("aw_handshake", awready, 1);
    aw_wait = n;
    @(posedge clk);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      if (i == abort_at) begin
        resetn = 1'b0;
        @(negedge clk); #1;
        chk_reset("rst_mid");
        resetn = 1'b1;
        return;
      end
      while (rnd && $urandom_range(3) == 0) begin
        #1;
        chk("w_gap_en", sram_en, 0);
        chk("w_gap_rdy", wready, 1);
        @(negedge clk);
      end
      d = $urandom;
      s = rnd ? 4'($urandom) : 4'hF;
      wvalid = 1'b1; wdata = d; wstrb = s;
      #1;
      chk("w_ready", wready, 1);
      chk("w_sram_en", sram_en, 1);
      chk("w_sram_we", sram_we, s);
      chk("w_sram_addr", sram_addr, ea);
      chk("w_sram_wdata", sram_wdata, d);
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[ea[9:2]][8*b +: 8] = d[8*b +: 8];
      ea += 32'd4;
      @(posedge clk);
    end
    @(negedge clk);
    wvalid = 1'b0;
    if (rnd) begin
      repeat ($urandom_range(3)) begin
        wvalid = 1'($urandom); wdata = $urandom; wstrb = 4'hF;
        #1;
        chk("b_hold_v", bvalid, 1);
        chk("b_hold_id", bid, id);
        chk("b_no_wr", sram_en, 0);
        chk("b_no_wready", wready, 0);
        @(negedge clk);
      end
      wvalid = 1'b0;
    end
    bready = 1'b1;
    #1;
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, 0);
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    #1;
    chk("b_drop", bvalid, 0);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input bit rnd, input int stall_beat);
    logic [31:0] ea, held;
    int          n, cyc, stb, st;
    ea = a & 32'hFFFF_FFFC;
    arvalid = 1'b1; arid = id; araddr = a; arlen = len;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    chk("ar_handshake", arready, 1);
    chk("aw_blocked", awready, 0);
    @(posedge clk);
    for (int i = 0; i <= int'(len); i++) begin
      cyc = 0; stb = 0;
      do begin
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b0;
        #1;
        cyc++;
        if (sram_en) begin
          stb++;
          chk("r_sram_addr", sram_addr, ea);
          chk("r_sram_we", sram_we, 0);
        end
      end while (!rvalid && cyc < 20);
      chk("r_latency", cyc, 3);
      chk("r_strobes", stb, 1);
      held = rdata;
      st = (i == stall_beat) ? 5 : (rnd ? int'($urandom_range(3)) : 0);
      repeat (st) begin
        @(negedge clk); #1;
        chk("r_hold_v", rvalid, 1);
        chk("r_hold_d", rdata, held);
        chk("r_hold_last", rlast, i == int'(len));
        chk("r_hold_no_en", sram_en, 0);
      end
      rready = 1'b1;
      chk("r_data", rdata, ref_mem[ea[9:2]]);
      chk("r_id", rid, id);
      chk("r_resp", rresp, 0);
      chk("r_last", rlast, i == int'(len));
      ea += 32'd4;
      @(posedge clk);
    end
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rid_v, rlen;
    logic [31:0] ra;
    resetn = 1'b0; sram_clr = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    arid = 0; araddr = 0; arlen = 0; arvalid = 0;
    wdata = 0; wstrb = 0; wvalid = 0; bready = 0; rready = 0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst_init");
    resetn = 1'b1; sram_clr = 1'b0;
    @(negedge clk); #1;
    chk("idle_arready", arready, 1);
    chk("idle_awready", awready, 1);
    @(negedge clk);

    do_write(4'hA, 32'h100, 4'd3, 1'b0, -1);
    @(negedge clk);
    do_read(4'h5, 32'h100, 4'd3, 1'b0, -1);
    do_read(4'h6, 32'h102, 4'd3, 1'b0, 1);

    // Simultaneous AW and AR: the read goes first, the write is taken in the first idle cycle after.
    awvalid = 1'b1; awid = 4'h7; awaddr = 32'h140; awlen = 4'd1;
    do_read(4'h2, 32'h100, 4'd1, 1'b0, -1);
    do_write(4'h7, 32'h140, 4'd1, 1'b0, -1);
    chk("aw_first_idle", aw_wait, 0);
    @(negedge clk);

    do_write(4'hC, 32'hFFFF_FFF8, 4'd3, 1'b1, -1);
    @(negedge clk);
    do_read(4'hD, 32'hFFFF_FFF9, 4'd3, 1'b0, -1);

    for (int t = 0; t < 30; t++) begin
      rid_v = 4'($urandom);
      ra    = $urandom_range(0, 32'h3FF);
      rlen  = 4'($urandom_range(15));
      if ($urandom_range(1) == 0) begin
        do_write(rid_v, ra, rlen, 1'b1, -1);
        @(negedge clk);
      end else begin
        do_read(rid_v, ra, rlen, 1'b1, -1);
      end
    end

    do_write(4'h3, 32'h200, 4'd3, 1'b0, 1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_no_b", bvalid, 0);
    end
    @(negedge clk);
    do_read(4'h9, 32'h200, 4'd3, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
